// File: rtl/font_pkg.sv
// Shared constants, FSM state type and address helper for the font ROM arbiter.
// Optional build macro used by the arbiter: FONT_ARB_OVERLAP_EN.
package font_pkg;

    localparam int unsigned FONT_GLYPH_WORDS = 512;
    localparam int unsigned GLYPH_ROWS       = 16;
    localparam int unsigned ROW_PIXELS       = 32;
    localparam int unsigned FONT_ADDR_W      = 13;

    localparam int unsigned CODE_W = 4;
    localparam int unsigned ROW_W  = $clog2(GLYPH_ROWS);
    localparam int unsigned COL_W  = $clog2(ROW_PIXELS);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN
    } state_t;

    // Word address of one pixel: glyph base + row base + column.
    function automatic logic [FONT_ADDR_W-1:0] glyph_addr(
        input logic [CODE_W-1:0] code,
        input logic [ROW_W-1:0]  row,
        input logic [COL_W-1:0]  col
    );
        return FONT_ADDR_W'(code) * FONT_ADDR_W'(FONT_GLYPH_WORDS)
             + FONT_ADDR_W'(row)  * FONT_ADDR_W'(ROW_PIXELS)
             + FONT_ADDR_W'(col);
    endfunction

endpackage

// File: rtl/font_rd_pipe.sv
// Return-path tag pipeline: carries valid/id/last alongside the ROM read latency.
// Synchronous clear drops every in-flight read tag.
module font_rd_pipe #(
    parameter int unsigned LATENCY = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rd_valid,
    input  logic rd_id,
    input  logic rd_last,
    output logic pix_valid,
    output logic pix_id,
    output logic pix_last,
    output logic occupied
);

    logic [LATENCY-1:0] vld;
    logic [LATENCY-1:0] tag_id;
    logic [LATENCY-1:0] tag_last;

    // id/last are qualified by valid so empty stages read as all-zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld      <= '0;
            tag_id   <= '0;
            tag_last <= '0;
        end else begin
            vld[0]      <= rd_valid;
            tag_id[0]   <= rd_valid & rd_id;
            tag_last[0] <= rd_valid & rd_last;
            for (int unsigned s = 1; s < LATENCY; s++) begin
                vld[s]      <= vld[s-1];
                tag_id[s]   <= tag_id[s-1];
                tag_last[s] <= tag_last[s-1];
            end
        end
    end

    assign pix_valid = vld[LATENCY-1];
    assign pix_id    = tag_id[LATENCY-1];
    assign pix_last  = tag_last[LATENCY-1];
    assign occupied  = |vld;

endmodule

// File: rtl/font_rom_arbiter.sv
// Two-requester round-robin arbiter streaming one 32-pixel glyph row per grant from a font ROM.
// Build macro FONT_ARB_OVERLAP_EN: skip DRAIN so the next grant overlaps the previous row's returns.
module font_rom_arbiter
    import font_pkg::*;
#(
    parameter int unsigned ROM_LATENCY = 2
) (
    input  logic                   clk_50MHz,
    input  logic                   reset_n,
    input  logic                   req0_valid,
    input  logic [CODE_W-1:0]      req0_code,
    input  logic [ROW_W-1:0]       req0_row,
    input  logic                   req1_valid,
    input  logic [CODE_W-1:0]      req1_code,
    input  logic [ROW_W-1:0]       req1_row,
    output logic                   req0_ready,
    output logic                   req1_ready,
    output logic                   rom_en,
    output logic [FONT_ADDR_W-1:0] rom_addr,
    input  logic                   rom_data,
    output logic                   pix_valid,
    output logic                   pix_data,
    output logic                   pix_id,
    output logic                   pix_last,
    output logic                   busy
);

    localparam int unsigned DRAIN_W = 2;

    state_t                 state, state_nx;
    logic [COL_W-1:0]       col, col_nx;
    logic [DRAIN_W-1:0]     drain, drain_nx;
    logic [CODE_W-1:0]      code, code_nx;
    logic [ROW_W-1:0]       row, row_nx;
    logic                   id, id_nx;
    logic                   rr_last, rr_nx;
    logic                   rom_en_nx;
    logic [FONT_ADDR_W-1:0] rom_addr_nx;
    logic                   last_col;
    logic                   occupied;

    assign last_col = (col == COL_W'(ROW_PIXELS - 1));

    // rr_last holds the previous winner; resetting it to 1 gives req0 first priority.
    always_ff @(posedge clk_50MHz) begin
        if (!reset_n) begin
            state    <= IDLE;
            col      <= '0;
            drain    <= '0;
            code     <= '0;
            row      <= '0;
            id       <= 1'b0;
            rr_last  <= 1'b1;
            rom_en   <= 1'b0;
            rom_addr <= '0;
        end else begin
            state    <= state_nx;
            col      <= col_nx;
            drain    <= drain_nx;
            code     <= code_nx;
            row      <= row_nx;
            id       <= id_nx;
            rr_last  <= rr_nx;
            rom_en   <= rom_en_nx;
            rom_addr <= rom_addr_nx;
        end
    end

    always_comb begin
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        state_nx    = state;
        col_nx      = col;
        drain_nx    = drain;
        code_nx     = code;
        row_nx      = row;
        id_nx       = id;
        rr_nx       = rr_last;
        rom_en_nx   = 1'b0;
        rom_addr_nx = rom_addr;
        case (state)
            IDLE: begin
                if (reset_n) begin
                    req0_ready = req0_valid && (!req1_valid || rr_last);
                    req1_ready = req1_valid && (!req0_valid || !rr_last);
                end
                if (req0_ready || req1_ready) begin
                    id_nx       = req1_ready;
                    code_nx     = req1_ready ? req1_code : req0_code;
                    row_nx      = req1_ready ? req1_row : req0_row;
                    rr_nx       = req1_ready;
                    col_nx      = '0;
                    rom_en_nx   = 1'b1;
                    rom_addr_nx = glyph_addr(code_nx, row_nx, COL_W'(0));
                    state_nx    = BURST;
                end
            end
            BURST: begin
                if (last_col) begin
`ifdef FONT_ARB_OVERLAP_EN
                    state_nx = IDLE;
`else
                    state_nx = DRAIN;
                    drain_nx = DRAIN_W'(ROM_LATENCY - 1);
`endif
                end else begin
                    col_nx      = col + COL_W'(1);
                    rom_en_nx   = 1'b1;
                    rom_addr_nx = glyph_addr(code, row, col_nx);
                end
            end
            DRAIN: begin
                if (drain == '0) begin
                    state_nx = IDLE;
                end else begin
                    drain_nx = drain - DRAIN_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    font_rd_pipe #(
        .LATENCY(ROM_LATENCY)
    ) u_rd_pipe (
        .clk      (clk_50MHz),
        .reset_n  (reset_n),
        .rd_valid (rom_en),
        .rd_id    (id),
        .rd_last  (last_col),
        .pix_valid(pix_valid),
        .pix_id   (pix_id),
        .pix_last (pix_last),
        .occupied (occupied)
    );

    // ROM data is only meaningful in a valid return slot.
    assign pix_data = pix_valid & rom_data;
    assign busy     = (state != IDLE) || occupied;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Bench for font_rom_arbiter: three instances (ROM_LATENCY 2, 1, 4) share stimulus and are
// checked every cycle against a per-request schedule model; honours FONT_ARB_OVERLAP_EN.
module tb_font_rom_arbiter;

    localparam int NC = 4000;
`ifdef FONT_ARB_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_code, req1_code, req0_row, req1_row;

    logic        rdy0 [3];
    logic        rdy1 [3];
    logic        en [3];
    logic [12:0] addr [3];
    logic        rom_data [3];
    logic        pv [3];
    logic        pd [3];
    logic        pid [3];
    logic        plast [3];
    logic        busy [3];

    font_rom_arbiter #(.ROM_LATENCY(2)) dut (
        .clk_50MHz(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_code(req0_code), .req0_row(req0_row),
        .req1_valid(req1_valid), .req1_code(req1_code), .req1_row(req1_row),
        .req0_ready(rdy0[0]), .req1_ready(rdy1[0]),
        .rom_en(en[0]), .rom_addr(addr[0]), .rom_data(rom_data[0]),
        .pix_valid(pv[0]), .pix_data(pd[0]), .pix_id(pid[0]), .pix_last(plast[0]),
        .busy(busy[0])
    );

    font_rom_arbiter #(.ROM_LATENCY(1)) u_lat1 (
        .clk_50MHz(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_code(req0_code), .req0_row(req0_row),
        .req1_valid(req1_valid), .req1_code(req1_code), .req1_row(req1_row),
        .req0_ready(rdy0[1]), .req1_ready(rdy1[1]),
        .rom_en(en[1]), .rom_addr(addr[1]), .rom_data(rom_data[1]),
        .pix_valid(pv[1]), .pix_data(pd[1]), .pix_id(pid[1]), .pix_last(plast[1]),
        .busy(busy[1])
    );

    font_rom_arbiter #(.ROM_LATENCY(4)) u_lat4 (
        .clk_50MHz(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_code(req0_code), .req0_row(req0_row),
        .req1_valid(req1_valid), .req1_code(req1_code), .req1_row(req1_row),
        .req0_ready(rdy0[2]), .req1_ready(rdy1[2]),
        .rom_en(en[2]), .rom_addr(addr[2]), .rom_data(rom_data[2]),
        .pix_valid(pv[2]), .pix_data(pd[2]), .pix_id(pid[2]), .pix_last(plast[2]),
        .busy(busy[2])
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit armed    = 1'b0;

    bit rom_bits [8192];

    // Expected per-cycle outputs, one row per instance.
    bit        exp_en    [3][NC];
    bit [12:0] exp_addr  [3][NC];
    bit        exp_pv    [3][NC];
    bit        exp_pid   [3][NC];
    bit        exp_plast [3][NC];
    bit        exp_pd    [3][NC];
    bit        exp_busy  [3][NC];
    int        next_free [3];
    bit        last_id   [3];
    bit [12:0] hold_addr [3];

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    endfunction

    task automatic chk(input string tag, input int k, input logic [12:0] obs, input logic [12:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s lat=%0d cyc=%0d observed=%0h expected=%0h", tag, lat_of(k), cyc, obs, exp);
        end
    endtask

    // ROM device model: returns the bit addressed lat cycles earlier, junk otherwise.
    logic        hist_en   [3][5];
    logic [12:0] hist_addr [3][5];
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                for (int d = 4; d > 0; d--) begin
                    hist_en[k][d]   = hist_en[k][d-1];
                    hist_addr[k][d] = hist_addr[k][d-1];
                end
                hist_en[k][0]   = en[k];
                hist_addr[k][0] = addr[k];
                if (hist_en[k][lat_of(k)] === 1'b1)
                    rom_data[k] = rom_bits[hist_addr[k][lat_of(k)]];
                else
                    rom_data[k] = 1'($urandom);
            end
        end
    end

    // Evaluate cycle cyc at the falling edge: arbitrate, check, schedule, apply reset.
    task automatic eval_cycle();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            int l;
            bit idle, e0, e1;
            l    = lat_of(k);
            idle = (reset_n === 1'b1) && (cyc >= next_free[k]);
            e0   = idle && req0_valid && (!req1_valid || last_id[k]);
            e1   = idle && req1_valid && (!req0_valid || !last_id[k]);
            if (armed) begin
                if (exp_en[k][cyc]) hold_addr[k] = exp_addr[k][cyc];
                chk("ready0",    k, 13'(rdy0[k]),  13'(e0));
                chk("ready1",    k, 13'(rdy1[k]),  13'(e1));
                chk("rom_en",    k, 13'(en[k]),    13'(exp_en[k][cyc]));
                chk("rom_addr",  k, addr[k],       hold_addr[k]);
                chk("pix_valid", k, 13'(pv[k]),    13'(exp_pv[k][cyc]));
                chk("pix_data",  k, 13'(pd[k]),    13'(exp_pv[k][cyc] & exp_pd[k][cyc]));
                chk("pix_id",    k, 13'(pid[k]),   13'(exp_pid[k][cyc]));
                chk("pix_last",  k, 13'(plast[k]), 13'(exp_plast[k][cyc]));
                chk("busy",      k, 13'(busy[k]),  13'(exp_busy[k][cyc]));
            end
            if (e0 || e1) begin
                int code, row;
                code = e1 ? int'(req1_code) : int'(req0_code);
                row  = e1 ? int'(req1_row)  : int'(req0_row);
                last_id[k]   = e1;
                next_free[k] = cyc + 33 + (OVL ? 0 : l);
                for (int col = 0; col < 32; col++) begin
                    int a, ti;
                    a  = code * 512 + row * 32 + col;
                    ti = cyc + 1 + col;
                    exp_en[k][ti]      = 1'b1;
                    exp_addr[k][ti]    = 13'(a);
                    exp_pv[k][ti+l]    = 1'b1;
                    exp_pid[k][ti+l]   = e1;
                    exp_plast[k][ti+l] = (col == 31);
                    exp_pd[k][ti+l]    = rom_bits[a];
                end
                for (int t = cyc + 1; t <= cyc + 32 + l; t++) exp_busy[k][t] = 1'b1;
            end
            if (reset_n !== 1'b1) begin
                for (int t = cyc + 1; t <= cyc + 40 && t < NC; t++) begin
                    exp_en[k][t] = 0; exp_pv[k][t] = 0; exp_pid[k][t] = 0;
                    exp_plast[k][t] = 0; exp_pd[k][t] = 0; exp_busy[k][t] = 0;
                end
                next_free[k] = cyc + 1;
                last_id[k]   = 1'b1;
                hold_addr[k] = '0;
            end
        end
        if (reset_n !== 1'b1) armed = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc > NC - 64) begin
            $display("FAIL cycle_budget cyc=%0d exceeds %0d", cyc, NC - 64);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    task automatic tick();
        eval_cycle();
        next_cycle();
    endtask

    task automatic idle_cycles(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (n) tick();
    endtask

    int t0, g, n, t_first;

    initial begin
        for (int a = 0; a < 8192; a++) rom_bits[a] = 1'($urandom);
        for (int k = 0; k < 3; k++) begin
            next_free[k] = 0;
            last_id[k]   = 1'b1;
            hold_addr[k] = '0;
            rom_data[k]  = 1'b0;
        end
        reset_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_code = '0; req1_code = '0; req0_row = '0; req1_row = '0;
        @(posedge clk);
        #1;
        repeat (3) tick();
        reset_n = 1'b1;
        idle_cycles(2);

        // Single req0 row: glyph A, row 3.
        t0 = cyc;
        req0_valid = 1'b1; req0_code = 4'hA; req0_row = 4'd3;
        tick();
        req0_valid = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            eval_cycle();
            if (i == 1)  chk("first_addr",  0, addr[0], 13'd5216);
            if (i == 32) chk("last_addr",   0, addr[0], 13'd5247);
            if (i == 34) chk("last_pixel",  0, 13'(plast[0] & pv[0]), 13'd1);
            if (i == 2)  chk("first_pix_l1", 1, 13'(pv[1]), 13'd1);
            if (i == 5)  chk("first_pix_l4", 2, 13'(pv[2]), 13'd1);
            next_cycle();
        end

        // Both held valid after reset: strict alternation starting with req0.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        g = 0;
        n = 0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        while (g < 4 && n < 200) begin
            req0_code = 4'($urandom); req0_row = 4'($urandom);
            req1_code = 4'($urandom); req1_row = 4'($urandom);
            eval_cycle();
            if (rdy0[0] === 1'b1 || rdy1[0] === 1'b1) begin
                chk("rr_order", 0, 13'(rdy1[0]), 13'(g % 2));
                g++;
            end
            next_cycle();
            n++;
        end
        chk("rr_grants", 0, 13'(g), 13'd4);
        idle_cycles(45);

        // Highest glyph/row: addresses end at 8191 without wrapping.
        req1_valid = 1'b1; req1_code = 4'hF; req1_row = 4'd15;
        t0 = cyc;
        tick();
        req1_valid = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            eval_cycle();
            if (i == 1)  chk("top_first_addr", 0, addr[0], 13'd8160);
            if (i == 33) chk("top_hold_addr",  0, addr[0], 13'd8191);
            next_cycle();
        end

        // Reset mid-burst at column 10, then both valid.
        req0_valid = 1'b1; req0_code = 4'($urandom); req0_row = 4'($urandom);
        tick();
        req0_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 11) reset_n = 1'b0;
            if (i == 12) begin
                reset_n = 1'b1;
                req0_valid = 1'b1; req1_valid = 1'b1;
            end
            eval_cycle();
            if (i == 12) begin
                chk("rst_rom_en",  0, 13'(en[0]),   13'd0);
                chk("rst_pix",     0, 13'(pv[0]),   13'd0);
                chk("rst_grant0",  0, 13'(rdy0[0]), 13'd1);
            end
            next_cycle();
        end
        idle_cycles(45);

        // Back-to-back req0: spacing of the two grants.
        req0_valid = 1'b1;
        g = 0;
        n = 0;
        t_first = 0;
        while (g < 2 && n < 100) begin
            eval_cycle();
            if (rdy0[0] === 1'b1) begin
                if (g == 0) t_first = cyc;
                else chk("b2b_spacing", 0, 13'(cyc - t_first), OVL ? 13'd33 : 13'd35);
                g++;
            end
            next_cycle();
            n++;
        end
        chk("b2b_grants", 0, 13'(g), 13'd2);
        idle_cycles(45);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1200; i++) begin
            reset_n    = ($urandom_range(0, 299) != 0);
            req0_valid = ($urandom_range(0, 3) == 0);
            req1_valid = ($urandom_range(0, 3) == 0);
            req0_code  = 4'($urandom); req0_row = 4'($urandom);
            req1_code  = 4'($urandom); req1_row = 4'($urandom);
            tick();
        end
        reset_n = 1'b1;
        idle_cycles(45);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/font_rom_arbiter.md
FONT_ROM_ARBITER -- requirements
Module: font_rom_arbiter

Interface
REQ-001 Parameter ROM_LATENCY, default 2, meaning: font ROM read latency in cycles (legal range 1..4).
REQ-002 clk_50MHz  in  1  sole clock; all logic on rising edge.
REQ-003 reset_n  in  1  reset, synchronous and active-low.
REQ-004 req0_valid / req1_valid  in  1  requester n wants one glyph row.
REQ-005 req0_code / req1_code  in  4  glyph code 0x0..0xF.
REQ-006 req0_row / req1_row  in  4  glyph row 0..15.
REQ-007 req0_ready / req1_ready  out  1  grant strobe; the request is accepted on the cycle valid&ready.
REQ-008 rom_en  out  1  ROM read enable.
REQ-009 rom_addr  out  13  ROM word address.
REQ-010 rom_data  in  1  pixel bit, valid ROM_LATENCY cycles after rom_en.
REQ-011 pix_valid  out  1  returned pixel is valid.
REQ-012 pix_data  out  1  returned pixel.
REQ-013 pix_id  out  1  owning requester: 0 or 1.
REQ-014 pix_last  out  1  marks pixel column 31 of the row.
REQ-015 busy  out  1  high if the state is not IDLE or any read is in flight.

Function
REQ-016 The FSM SHALL have the states IDLE, BURST and DRAIN.
REQ-017 In IDLE the arbiter SHALL assert exactly one readyN, combinationally, whenever at least one validN is high.
  - Only one valid: grant that requester.
  - Both valid: grant the requester not granted last (round-robin); after reset the pointer favours req0.
REQ-018 On acceptance at cycle T the block SHALL latch code, row and id, set the round-robin pointer to the winner, and enter BURST at T+1.
REQ-019 In BURST, for 32 consecutive cycles T+1..T+32, rom_en SHALL be 1 and rom_addr SHALL equal code*512 + row*32 + col, with col stepping 0..31.
REQ-020 Address arithmetic SHALL be unsigned 13-bit; the maximum address is 8191 and no wrap can occur.
REQ-021 For the read issued at T+1+col, pix_valid, pix_data (= rom_data), pix_id and pix_last (col==31) SHALL appear at cycle T+1+col+ROM_LATENCY.
REQ-022 After the col-31 issue the FSM SHALL go to DRAIN, or to IDLE per REQ-028.
REQ-023 DRAIN SHALL last ROM_LATENCY cycles, then go to IDLE.
REQ-024 readyN SHALL be 0 in BURST and DRAIN; validN and the request fields are sampled only at acceptance.
REQ-025 rom_en SHALL be 0 in IDLE and DRAIN, and rom_addr SHALL hold its last value there.

Reset
REQ-026 reset_n low at a clock edge SHALL, from the next cycle, force the following regardless of state or in-flight reads:
  - state IDLE;
  - rom_en 0, rom_addr 0;
  - every stage of the return pipeline invalid, so pix_valid, pix_data, pix_id and pix_last are 0;
  - ready 0 while reset is held;
  - busy 0;
  - round-robin pointer back to req0.
REQ-027 Data returning from the ROM for reads issued before reset SHALL be discarded.

Configuration
REQ-028 Macro FONT_ARB_OVERLAP_EN:
  - Defined: BURST goes directly to IDLE after the col-31 issue, so a new grant can occur at T+33 while the previous row's pixels still return.
  - Undefined: DRAIN is used and the next grant occurs no earlier than T+33+ROM_LATENCY.
  - In both builds, pixel order and pix_id tagging SHALL be preserved.

Structure
REQ-029 Shared package font_pkg SHALL hold:
  - FONT_GLYPH_WORDS=512, GLYPH_ROWS=16, ROW_PIXELS=32, FONT_ADDR_W=13;
  - the FSM state enum.
REQ-030 The return path SHALL be a sub-module font_rd_pipe:
  - ROM_LATENCY-deep shift register carrying valid, id and last, with synchronous clear;
  - busy is derived from its occupancy.

Verification
REQ-031 Single request, ROM_LATENCY=2: req0 code=0xA row=3 accepted at T -> rom_addr 5216..5247 on T+1..T+32; pix_valid T+3..T+34, pix_id 0, pix_last at T+34.
REQ-032 Both valid after reset, held high -> grants in order req0, req1, req0, req1; pix_id follows the same order; no pixel is lost.
REQ-033 req1 code=0xF row=15 -> rom_addr 8160..8191 with no wrap to 0.
REQ-034 Reset asserted during BURST at col 10 -> rom_en 0 and pix_valid 0 the next cycle; in-flight pixels dropped; next grant with both valid goes to req0.
REQ-035 Back-to-back req0 with ROM_LATENCY=2 -> second ready at T+35 without FONT_ARB_OVERLAP_EN, at T+33 with it; pix stream is contiguous with no id mixing.
REQ-036 ROM_LATENCY=1 and ROM_LATENCY=4 -> the first pixel of the row appears at T+2 and T+5 respectively.
